// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the FIFO frame builder.
// Imported by the interface, the builder and any integration top.
package fifo_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    LEN     = 3'd3,
    CSUM    = 3'd4
  } frame_state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Width of a counter that must hold 0..frame_len inclusive.
  function automatic int frame_len_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/fifo_frame_builder_if.sv
// Bus bundle between the FIFO read side, the frame builder and the output stream.
// The master modport is the builder's view; slave is the environment's view.
interface fifo_frame_builder_if #(
  parameter int WIDTH = 8
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_rd_en,
    output out_valid,
    output out_data,
    output out_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/fifo_frame_builder.sv
// Drains a FIFO and emits frames: SOF, 1..FRAME_LEN payload words, length, checksum.
// A partial frame is closed after TIMEOUT consecutive starved cycles.
module fifo_frame_builder
  import fifo_frame_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               FRAME_LEN = 4,
  parameter int               TIMEOUT   = 8,
  parameter logic [WIDTH-1:0] SOF       = WIDTH'(SOF_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_frame_builder_if.master bus
);

  localparam int CW = frame_len_w(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_FRAME_LEN = CW'(FRAME_LEN);
  localparam logic [TW-1:0] LP_TIMEOUT   = TW'(TIMEOUT);

  frame_state_e     r_state;
  logic [CW-1:0]    r_cnt;
  logic [TW-1:0]    r_tmo;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;

  logic             w_load;
  logic             w_rd_en;
  logic [CW-1:0]    w_cnt_inc;
  logic [TW-1:0]    w_tmo_inc;

  // The output register may take a new word when empty or being drained this cycle.
  assign w_load    = !r_out_valid || bus.out_ready;
  assign w_rd_en   = (r_state == PAYLOAD) && w_load && !bus.fifo_empty;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_tmo_inc = r_tmo + TW'(1);

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_last   = r_out_last;

  // Frame sequencer with registered output stage; nothing moves while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_sum       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          if (!bus.fifo_empty) begin
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_load) begin
            r_out_data  <= SOF;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_tmo       <= '0;
            r_state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_load) begin
            if (!bus.fifo_empty) begin
              r_out_data  <= bus.fifo_data;
              r_out_valid <= 1'b1;
              r_sum       <= r_sum + bus.fifo_data;
              r_cnt       <= w_cnt_inc;
              r_tmo       <= '0;
              if (w_cnt_inc == LP_FRAME_LEN) begin
                r_state <= LEN;
              end
            end else begin
              // Starved: at least one payload word is already out, so closing early is safe.
              r_out_valid <= 1'b0;
              r_tmo       <= w_tmo_inc;
              if (w_tmo_inc == LP_TIMEOUT) begin
                r_state <= LEN;
              end
            end
          end
        end
        LEN: begin
          if (w_load) begin
            r_out_data  <= WIDTH'(r_cnt);
            r_out_valid <= 1'b1;
            r_state     <= CSUM;
          end
        end
        CSUM: begin
          if (w_load) begin
            r_out_data  <= r_sum;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_builder.sv
// Directed bench for fifo_frame_builder: table of push/expect vectors plus
// hand-written backpressure and mid-frame reset sequences.
module tb_fifo_frame_builder;
  import fifo_frame_pkg::*;

  localparam int TMO = 8;

  logic clk;
  logic rst_n;

  fifo_frame_builder_if #(.WIDTH(8)) bus ();

  fifo_frame_builder #(
    .WIDTH(8), .FRAME_LEN(4), .TIMEOUT(TMO), .SOF(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: show-ahead data, popped on the edge where fifo_rd_en is high.
  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign bus.fifo_empty = (wp == rp);
  assign bus.fifo_data  = mem[rp % 64];
  always @(posedge clk) begin
    if (bus.fifo_rd_en && (wp != rp)) rp <= rp + 1;
  end

  // Output monitor, sampled mid-cycle.
  logic [7:0] cap_data [0:255];
  logic       cap_last [0:255];
  int         cap_cyc  [0:255];
  int cap_n = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_viol = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.out_valid && bus.out_ready && cap_n < 256) begin
      cap_data[cap_n] <= bus.out_data;
      cap_last[cap_n] <= bus.out_last;
      cap_cyc[cap_n]  <= cyc;
      cap_n           <= cap_n + 1;
    end
    if (bus.fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (bus.fifo_empty) rd_viol <= rd_viol + 1;
    end
  end

  typedef struct packed {
    logic [3:0]        n_in;
    logic [0:8][7:0]   din;
    logic [4:0]        n_out;
    logic [0:17][7:0]  dout;
    logic [0:17]       last_mask;
    logic [4:0]        gap_idx;
  } vec_t;

  vec_t vecs [0:3];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp % 64] = b;
    wp = wp + 1;
  endtask

  task automatic wait_caps(input int target, input string nm);
    int k;
    k = 0;
    while (cap_n < target && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " words within budget"}, (cap_n >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_word(input logic [7:0] w, input string nm);
    int k;
    k = 0;
    while (!(bus.out_valid && bus.out_data == w) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " word presented"}, (bus.out_valid && bus.out_data == w) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic cmp_frames(input vec_t v, input int base, input string nm);
    for (int j = 0; j < 18; j++) begin
      if (j < int'(v.n_out)) begin
        chk($sformatf("%s data[%0d]", nm, j), 32'(cap_data[base + j]), 32'(v.dout[j]));
        chk($sformatf("%s last[%0d]", nm, j), 32'(cap_last[base + j]), 32'(v.last_mask[j]));
      end
    end
  endtask

  initial begin
    int base;
    int rb;

    vecs[0] = '{n_in: 4'd4, din: {8'h01, 8'h02, 8'h03, 8'h04, 40'h0},
                n_out: 5'd7, dout: {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h0A, 88'h0},
                last_mask: 18'b000000100000000000, gap_idx: 5'd0};
    vecs[1] = '{n_in: 4'd2, din: {8'h10, 8'h20, 56'h0},
                n_out: 5'd5, dout: {8'hA5, 8'h10, 8'h20, 8'h02, 8'h30, 104'h0},
                last_mask: 18'b000010000000000000, gap_idx: 5'd3};
    vecs[2] = '{n_in: 4'd4, din: {8'hFF, 8'hFF, 8'hFF, 8'h03, 40'h0},
                n_out: 5'd7, dout: {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h04, 8'h00, 88'h0},
                last_mask: 18'b000000100000000000, gap_idx: 5'd0};
    vecs[3] = '{n_in: 4'd9,
                din: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09},
                n_out: 5'd18,
                dout: {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h0A,
                       8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h04, 8'h1A,
                       8'hA5, 8'h09, 8'h01, 8'h09},
                last_mask: 18'b000000100000010001, gap_idx: 5'd0};

    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset out_last", 32'(bus.out_last), 32'd0);
    chk("reset fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      base = cap_n;
      rb = rd_cnt;
      for (int j = 0; j < 9; j++) begin
        if (j < int'(vecs[i].n_in)) push(vecs[i].din[j]);
      end
      wait_caps(base + int'(vecs[i].n_out), $sformatf("vec%0d", i));
      repeat (12) @(posedge clk);
      #1;
      cmp_frames(vecs[i], base, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d word count", i), 32'(cap_n - base), 32'(vecs[i].n_out));
      chk($sformatf("vec%0d read pulses", i), 32'(rd_cnt - rb), 32'(vecs[i].n_in));
      if (vecs[i].gap_idx != 5'd0) begin
        chk($sformatf("vec%0d starve gap", i),
            32'(cap_cyc[base + int'(vecs[i].gap_idx)] - cap_cyc[base + int'(vecs[i].gap_idx) - 1]),
            32'(TMO + 1));
      end
    end

    // Backpressure: stall while 02 is on the output.
    base = cap_n;
    rb = rd_cnt;
    for (int j = 1; j <= 4; j++) push(8'(j));
    wait_word(8'h02, "bp");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold valid %0d", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp hold data %0d", k), 32'(bus.out_data), 32'h02);
      chk($sformatf("bp hold last %0d", k), 32'(bus.out_last), 32'd0);
      chk($sformatf("bp no read %0d", k), 32'(bus.fifo_rd_en), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_caps(base + 7, "bp");
    repeat (4) @(posedge clk);
    #1;
    cmp_frames(vecs[0], base, "bp");
    chk("bp word count", 32'(cap_n - base), 32'd7);
    chk("bp read pulses", 32'(rd_cnt - rb), 32'd4);

    // Reset mid-frame after the second payload word is presented.
    push(8'h01);
    push(8'h02);
    wait_word(8'h02, "rst");
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset out_data", 32'(bus.out_data), 32'd0);
    chk("midreset out_last", 32'(bus.out_last), 32'd0);
    chk("midreset fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset hold valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    base = cap_n;
    repeat (15) @(posedge clk);
    #1;
    chk("midreset no trailer", 32'(cap_n - base), 32'd0);
    push(8'h07);
    wait_caps(base + 4, "post-reset");
    repeat (4) @(posedge clk);
    #1;
    chk("post-reset data[0]", 32'(cap_data[base]), 32'hA5);
    chk("post-reset data[1]", 32'(cap_data[base + 1]), 32'h07);
    chk("post-reset data[2]", 32'(cap_data[base + 2]), 32'h01);
    chk("post-reset data[3]", 32'(cap_data[base + 3]), 32'h07);
    chk("post-reset last[2]", 32'(cap_last[base + 2]), 32'd0);
    chk("post-reset last[3]", 32'(cap_last[base + 3]), 32'd1);
    chk("post-reset word count", 32'(cap_n - base), 32'd4);

    chk("no read while empty", 32'(rd_viol), 32'd0);
    chk("fifo fully drained", 32'(wp - rp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
